// File: rtl/pc_sequencer.sv
// Program counter with prioritised next-PC selection, stall, and an internal
// circular return-address stack. Error pulses are registered for the control unit.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     INC          = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       branch_taken,
    input  logic [XLEN-1:0]            branch_target,
    input  logic                       jump,
    input  logic [XLEN-1:0]            jump_target,
    input  logic                       is_call,
    input  logic                       is_ret,
    input  logic                       trap,
    output logic [XLEN-1:0]            pc,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_full,
    output logic                       ras_empty,
    output logic                       misalign_err,
    output logic                       ras_underflow
);

    localparam int unsigned     PTR_W      = $clog2(RAS_DEPTH);
    localparam int unsigned     CNT_W      = PTR_W + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] rasCnt_q, rasCnt_d;
    logic [PTR_W-1:0] rasPtr_q, rasPtr_d;
    logic             misalign_q, misalign_d;
    logic             underflow_q, underflow_d;

    logic [XLEN-1:0]  rasMem [RAS_DEPTH];
    logic             rasWe;
    logic [PTR_W-1:0] rasWaddr;
    logic [PTR_W-1:0] topIdx;
    logic [XLEN-1:0]  topEntry;
    logic [XLEN-1:0]  pcInc;
    logic             rasFull;
    logic             rasEmpty;

    assign pcInc    = pc_q + XLEN'(INC);
    assign topIdx   = rasPtr_q - PTR_W'(1);
    assign topEntry = rasMem[topIdx];
    assign rasFull  = (rasCnt_q == CNT_W'(RAS_DEPTH));
    assign rasEmpty = (rasCnt_q == '0);

    // rasPtr_q is the next write slot; the top of stack sits just below it,
    // so a push onto a full stack naturally overwrites the oldest entry.
    always_comb begin
        pc_d        = pc_q;
        rasCnt_d    = rasCnt_q;
        rasPtr_d    = rasPtr_q;
        misalign_d  = 1'b0;
        underflow_d = 1'b0;
        rasWe       = 1'b0;
        rasWaddr    = rasPtr_q;

        if (trap) begin
            pc_d = TRAP_VECTOR;
        end else if (enable) begin
            if (is_ret) begin
                if (rasEmpty) begin
                    pc_d        = TRAP_VECTOR;
                    underflow_d = 1'b1;
                end else if ((topEntry & ALIGN_MASK) != '0) begin
                    pc_d       = TRAP_VECTOR;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = topEntry;
                    if (jump && is_call) begin
                        rasWe    = 1'b1;
                        rasWaddr = topIdx;
                    end else begin
                        rasPtr_d = topIdx;
                        rasCnt_d = rasCnt_q - CNT_W'(1);
                    end
                end
            end else if (jump) begin
                if ((jump_target & ALIGN_MASK) != '0) begin
                    pc_d       = TRAP_VECTOR;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = jump_target;
                    if (is_call) begin
                        rasWe    = 1'b1;
                        rasWaddr = rasPtr_q;
                        rasPtr_d = rasPtr_q + PTR_W'(1);
                        if (!rasFull) begin
                            rasCnt_d = rasCnt_q + CNT_W'(1);
                        end
                    end
                end
            end else if (branch_taken) begin
                if ((branch_target & ALIGN_MASK) != '0) begin
                    pc_d       = TRAP_VECTOR;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = branch_target;
                end
            end else begin
                pc_d = pcInc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_VECTOR;
            rasCnt_q    <= '0;
            rasPtr_q    <= '0;
            misalign_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            rasCnt_q    <= rasCnt_d;
            rasPtr_q    <= rasPtr_d;
            misalign_q  <= misalign_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: a zero count already makes every entry invalid.
    always_ff @(posedge clk) begin
        if (rasWe) begin
            rasMem[rasWaddr] <= pcInc;
        end
    end

    assign pc            = pc_q;
    assign ras_count     = rasCnt_q;
    assign ras_full      = rasFull;
    assign ras_empty     = rasEmpty;
    assign misalign_err  = misalign_q;
    assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a queue-based reference model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_pc_sequencer;

    localparam logic [31:0] TRAP  = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        is_call;
    logic        is_ret;
    logic        trap;
    logic [31:0] pc;
    logic [2:0]  ras_count;
    logic        ras_full;
    logic        ras_empty;
    logic        misalign_err;
    logic        ras_underflow;

    int checkCount = 0;
    int failCount  = 0;
    bit checkEn    = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .is_call       (is_call),
        .is_ret        (is_ret),
        .trap          (trap),
        .pc            (pc),
        .ras_count     (ras_count),
        .ras_full      (ras_full),
        .ras_empty     (ras_empty),
        .misalign_err  (misalign_err),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the stack is a queue whose back is the top entry.
    logic [31:0] mPc;
    logic [31:0] mRas[$];
    bit          mMis;
    bit          mUnd;
    logic [31:0] mNext;
    logic [31:0] mTgt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mPc = 32'h0;
            mRas.delete();
            mMis = 0;
            mUnd = 0;
        end else begin
            mMis  = 0;
            mUnd  = 0;
            mNext = mPc + 32'd4;
            if (trap) begin
                mPc = TRAP;
            end else if (enable) begin
                if (is_ret) begin
                    if (mRas.size() == 0) begin
                        mPc  = TRAP;
                        mUnd = 1;
                    end else begin
                        mTgt = mRas[$];
                        if ((mTgt % 32'd4) != 0) begin
                            mPc  = TRAP;
                            mMis = 1;
                        end else begin
                            mPc = mTgt;
                            void'(mRas.pop_back());
                            if (jump && is_call) mRas.push_back(mNext);
                        end
                    end
                end else if (jump) begin
                    if ((jump_target % 32'd4) != 0) begin
                        mPc  = TRAP;
                        mMis = 1;
                    end else begin
                        mPc = jump_target;
                        if (is_call) begin
                            mRas.push_back(mNext);
                            if (mRas.size() > DEPTH) void'(mRas.pop_front());
                        end
                    end
                end else if (branch_taken) begin
                    if ((branch_target % 32'd4) != 0) begin
                        mPc  = TRAP;
                        mMis = 1;
                    end else begin
                        mPc = branch_target;
                    end
                end else begin
                    mPc = mNext;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && checkEn) begin
            checkOutput("model pc", pc, mPc);
            checkOutput("model ras_count", 32'(ras_count), 32'(mRas.size()));
            checkOutput("model ras_full", 32'(ras_full), 32'(mRas.size() == DEPTH));
            checkOutput("model ras_empty", 32'(ras_empty), 32'(mRas.size() == 0));
            checkOutput("model misalign_err", 32'(misalign_err), 32'(mMis));
            checkOutput("model ras_underflow", 32'(ras_underflow), 32'(mUnd));
        end
    end

    // Drive one cycle of requests, then return at the following falling edge.
    task automatic applyStimulus(input bit en, input bit br, input logic [31:0] bt,
                                 input bit jp, input logic [31:0] jt,
                                 input bit call, input bit ret, input bit trp);
        enable        = en;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        is_call       = call;
        is_ret        = ret;
        trap          = trp;
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 0; branch_taken = 0; branch_target = 0; jump = 0;
        jump_target = 0; is_call = 0; is_ret = 0; trap = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        checkEn = 1;
        checkOutput("reset pc", pc, 32'h0);
        checkOutput("reset ras_count", 32'(ras_count), 32'd0);
        checkOutput("reset ras_empty", 32'(ras_empty), 32'd1);

        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("seq pc", pc, 32'hC);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall pc", pc, 32'hC);

        #2 reset_n = 1'b0;
        #1 checkOutput("async reset pc", pc, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pc before call", pc, 32'h10);
        applyStimulus(1, 0, 0, 1, 32'h200, 1, 0, 0);
        checkOutput("call pc", pc, 32'h200);
        checkOutput("call count", 32'(ras_count), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("ret pc", pc, 32'h14);
        checkOutput("ret empty", 32'(ras_empty), 32'd1);

        doReset();
        for (int i = 1; i <= 5; i++) applyStimulus(1, 0, 0, 1, 32'(i) * 32'h100, 1, 0, 0);
        checkOutput("nested full", 32'(ras_full), 32'd1);
        checkOutput("nested count", 32'(ras_count), 32'd4);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("ret1 pc", pc, 32'h404);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("ret2 pc", pc, 32'h304);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("ret3 pc", pc, 32'h204);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("ret4 pc", pc, 32'h104);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("underflow pc", pc, TRAP);
        checkOutput("underflow pulse", 32'(ras_underflow), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("underflow clear", 32'(ras_underflow), 32'd0);

        applyStimulus(1, 1, 32'h102, 0, 0, 0, 0, 0);
        checkOutput("misalign pc", pc, TRAP);
        checkOutput("misalign pulse", 32'(misalign_err), 32'd1);
        applyStimulus(1, 1, 32'h400, 1, 32'h300, 0, 0, 0);
        checkOutput("jump over branch", pc, 32'h300);
        checkOutput("misalign clear", 32'(misalign_err), 32'd0);

        applyStimulus(1, 0, 0, 1, 32'h600, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("trap stalled pc", pc, TRAP);
        applyStimulus(1, 0, 0, 1, 32'h800, 1, 1, 1);
        checkOutput("trap priority pc", pc, TRAP);
        checkOutput("trap keeps count", 32'(ras_count), 32'd1);

        applyStimulus(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wrap pc", pc, 32'h0);

        applyStimulus(1, 0, 0, 1, 32'h84, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 32'h40, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 32'h500, 1, 1, 0);
        checkOutput("ret+call pc", pc, 32'h88);
        checkOutput("ret+call count", 32'(ras_count), 32'd2);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("replaced top", pc, 32'h44);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("older entry", pc, 32'h304);

        applyStimulus(1, 0, 0, 1, 32'h202, 1, 0, 0);
        checkOutput("misaligned call pc", pc, TRAP);
        checkOutput("misaligned call no push", 32'(ras_count), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        checkEn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the single-cycle/pipelined core. It holds the PC, selects the next PC from sequential, branch, jump, return and trap sources by fixed priority, and supports stall. It contains an internal return-address stack (RAS) for call/return, and registers alignment and underflow error pulses for the control unit. It sits between the control/branch logic and instruction memory.

Parameters:
XLEN, 32, PC and target width in bits
RESET_VECTOR, 0, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or error
INC, 4, sequential increment in bytes (power of 2)
RAS_DEPTH, 4, return-stack entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = advance PC this cycle; 0 = stall
branch_taken  in  1  take branch_target
branch_target  in  XLEN  branch destination
jump  in  1  unconditional jump to jump_target
jump_target  in  XLEN  jump destination
is_call  in  1  qualifies jump: also push pc+INC to RAS
is_ret  in  1  return: pop RAS top into PC
trap  in  1  force PC to TRAP_VECTOR
pc  out  XLEN  current PC
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_full  out  1  ras_count == RAS_DEPTH (combinational from count)
ras_empty  out  1  ras_count == 0 (combinational from count)
misalign_err  out  1  one-cycle pulse: rejected misaligned target
ras_underflow  out  1  one-cycle pulse: return with empty RAS

Behaviour:
- Reset (reset_n low, asynchronous, any time): pc=RESET_VECTOR, ras_count=0, RAS storage pointer=0, misalign_err=0, ras_underflow=0. Reset mid-stall or mid-call discards all RAS contents.
- All state updates on rising clk. Error pulses are registered, high for exactly the cycle after the event, and cleared every other cycle.
- Priority, highest first: trap > is_ret > jump > branch_taken > sequential (pc+INC, modulo 2^XLEN wrap).
- trap acts even when enable=0: pc<=TRAP_VECTOR, RAS unchanged, all other requests ignored.
- enable=0 and no trap: pc, RAS and ras_count hold. Requests are dropped; they are not queued.
- is_ret (enable=1): if ras_count>0, pc<=top entry and ras_count decrements. If ras_count==0, pc<=TRAP_VECTOR and ras_underflow pulses.
- is_ret with jump&is_call in the same cycle: pc<=top entry and the top is replaced with pc+INC, so ras_count is unchanged. If the RAS is empty, the underflow rule applies and no push occurs.
- jump (enable=1): pc<=jump_target. If is_call=1, push pc+INC (current pc). is_call without jump is ignored.
- Push when ras_full: the oldest entry is overwritten (circular), ras_count stays RAS_DEPTH, and no error is raised.
- Alignment: any selected jump/branch/return target with bits [$clog2(INC)-1:0] != 0 is rejected. pc<=TRAP_VECTOR, misalign_err pulses, and no RAS push/pop takes effect.
- Sequential pc+INC at 2^XLEN-INC wraps to 0 silently.
- No combinational path from inputs to pc.

Test Plan:
- Reset then 3 enabled cycles -> pc 0x0, 0x4, 0x8, 0xC. Deassert enable for 2 cycles -> pc holds 0xC. Pulse reset_n low between clock edges -> pc=0 immediately.
- At pc=0x10, jump=1 is_call=1 jump_target=0x200 -> pc=0x200, ras_count=1. Next cycle is_ret -> pc=0x14, ras_count=0, ras_empty=1.
- 5 nested calls from pcs 0x0,0x100,0x200,0x300,0x400 with RAS_DEPTH=4 -> ras_full=1, count=4. Then 4 returns -> 0x404, 0x304, 0x204, 0x104. A 5th return -> pc=0x100 (TRAP_VECTOR), ras_underflow high one cycle.
- branch_taken with branch_target=0x102 -> pc=0x100, misalign_err pulses one cycle. Simultaneous jump=0x300 and branch_taken=0x400 -> pc=0x300.
- enable=0 with trap=1 -> pc=0x100. enable=1 with trap, is_ret and jump all high -> pc=0x100 and ras_count unchanged.
- pc=0xFFFF_FFFC sequential -> pc=0x0. Simultaneous is_ret + call to 0x500 at pc=0x40 with top=0x88 -> pc=0x88, top=0x44, count unchanged.
